// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response channel
// plus the buffered instruction channel toward decode.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] encoded_value;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output encoded_value,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  encoded_value,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// buffers fetched words for decode and restarts on execute redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         misaligned_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        FAULT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state;
    state_t      state_n;
    logic        drop;
    logic        drop_n;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_n;
    logic [31:0] req_pc;

    entry_t      buf_q [FIFO_DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;

    logic full;
    logic req_fire;
    logic rsp_in_wait;
    logic push;
    logic pop;
    logic mis;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    assign full = (count >= CW'(FIFO_DEPTH));
    assign mis  = (redirect_pc[1:0] != 2'b00);

    // Gated by redirect so a request handshake never races a redirect.
    assign bus.imem_req_valid = rst_n && (state == FETCH)
                              && !full && !redirect_valid;
    assign bus.imem_req_addr  = fetch_pc;

    assign bus.instr_valid    = rst_n && (count != '0);
    assign bus.encoded_value  = buf_q[rptr].instr;
    assign bus.instr_pc       = buf_q[rptr].pc;

    assign misaligned_fault   = rst_n && (state == FAULT);

    assign req_fire    = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_in_wait = (state == WAIT) && bus.imem_rsp_valid;
    assign push        = rst_n && rsp_in_wait && !drop && !redirect_valid;
    assign pop         = bus.instr_valid && bus.instr_ready
                       && !redirect_valid;

    always_comb begin
        state_n    = state;
        drop_n     = drop;
        fetch_pc_n = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_n = redirect_pc;
            if ((state == WAIT) && !bus.imem_rsp_valid) begin
                // Response still in flight: swallow it when it lands.
                drop_n  = 1'b1;
                state_n = mis ? FAULT : WAIT;
            end else begin
                drop_n  = 1'b0;
                state_n = mis ? FAULT : FETCH;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (req_fire) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        drop_n  = 1'b0;
                        state_n = FETCH;
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            drop     <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_n;
            drop     <= drop_n;
            fetch_pc <= fetch_pc_n;
            if (req_fire)
                req_pc <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            if (push)
                wptr <= ptr_inc(wptr);
            if (pop)
                rptr <= ptr_inc(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            buf_q[wptr] <= '{pc: req_pc, instr: bus.imem_rsp_data};
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model answers in order,
// expected {pc, word} pairs are queued on accept and checked on pop.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned_fault;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .misaligned_fault (misaligned_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] acc_addr [$];
    int          acc_cyc [$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int pops = 0;
    int pc4_seen = 0;
    int spurious = 0;
    int acc_total = 0;
    logic [31:0] acc_last;

    int rsp_delay = 1;
    int inject_cyc = -10;
    int mem_seen = 0;
    bit pend = 1'b0;
    int cnt = 0;
    logic [31:0] paddr;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor: sample mid-cycle, before the next active edge.
    always @(negedge clk) begin
        if (!rst_n || redirect_valid) begin
            sb.delete();
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                sb.push_back('{pc: bus.imem_req_addr,
                               w: word(bus.imem_req_addr)});
                acc_addr.push_back(bus.imem_req_addr);
                acc_cyc.push_back(cyc);
                acc_last = bus.imem_req_addr;
                acc_total++;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (bus.instr_pc == 32'h4)
                    pc4_seen++;
                if (sb.size() == 0) begin
                    spurious++;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pop_pc", bus.instr_pc, e.pc);
                    check("pop_data", bus.encoded_value, e.w);
                    pops++;
                end
            end
        end
    end

    // Instruction memory: one in-order response rsp_delay cycles after accept.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.imem_rsp_valid = 1'b0;
            if (acc_total != mem_seen) begin
                mem_seen = acc_total;
                pend  = 1'b1;
                cnt   = rsp_delay;
                paddr = acc_last;
            end
            if (!rst_n)
                pend = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = word(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (cyc == inject_cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        check("rst_req_valid", 32'(bus.imem_req_valid), 0);
        check("rst_instr_valid", 32'(bus.instr_valid), 0);
        check("rst_fault", 32'(misaligned_fault), 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int i;
        for (i = 0; i < 40; i++) begin
            @(posedge clk);
            if (acc_addr.size() >= n)
                break;
        end
        #1;
        check(tag, 32'(acc_addr.size() >= n), 1);
    endtask

    initial begin
        int base;
        int c0;
        int c1;
        int p0;
        int bad;
        int q0;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;

        // Streaming fetch from reset.
        rsp_delay = 1;
        base = acc_addr.size();
        do_reset();
        c0 = -100;
        c1 = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                c0 = cyc;
                break;
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                c1 = cyc;
                break;
            end
        end
        check("t1_first_valid_lat", 32'(c1 - c0), 2);
        wait_acc(base + 3, "t1_wait");
        check("t1_addr0", acc_addr[base], 32'h0);
        check("t1_addr1", acc_addr[base + 1], 32'h4);
        check("t1_addr2", acc_addr[base + 2], 32'h8);
        check("t1_gap01", 32'(acc_cyc[base + 1] - acc_cyc[base]), 2);
        check("t1_gap12", 32'(acc_cyc[base + 2] - acc_cyc[base + 1]), 2);

        // Back-pressure: buffer fills, fetch stalls, head holds.
        bus.instr_ready = 1'b0;
        base = acc_addr.size();
        do_reset();
        step(12);
        check("t2_nreq", 32'(acc_addr.size() - base), 2);
        check("t2_addr0", acc_addr[base], 32'h0);
        check("t2_addr1", acc_addr[base + 1], 32'h4);
        check("t2_req_stall", 32'(bus.imem_req_valid), 0);
        check("t2_valid", 32'(bus.instr_valid), 1);
        check("t2_head_pc", bus.instr_pc, 32'h0);
        check("t2_head_data", bus.encoded_value, word(32'h0));
        step(3);
        check("t2_hold_pc", bus.instr_pc, 32'h0);
        check("t2_hold_data", bus.encoded_value, word(32'h0));
        p0 = pops;
        bus.instr_ready = 1'b1;
        wait_acc(base + 3, "t2_wait");
        check("t2_resume_addr", acc_addr[base + 2], 32'h8);
        check("t2_pops", 32'(pops - p0), 2);

        // Redirect one cycle before the in-flight response lands.
        rsp_delay = 2;
        base = acc_addr.size();
        do_reset();
        wait_acc(base + 2, "t3_wait");
        check("t3_addr1", acc_addr[base + 1], 32'h4);
        q0 = pc4_seen;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        wait_acc(base + 3, "t3_wait2");
        check("t3_redir_addr", acc_addr[base + 2], 32'h100);
        p0 = pops;
        step(4);
        check("t3_pops", 32'(pops - p0), 1);
        check("t3_no_pc4", 32'(pc4_seen - q0), 0);

        // Redirect coinciding with the response for 0x8.
        rsp_delay = 1;
        base = acc_addr.size();
        do_reset();
        wait_acc(base + 3, "t4_wait");
        check("t4_addr2", acc_addr[base + 2], 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step(1);
        redirect_valid = 1'b0;
        check("t4_empty", 32'(bus.instr_valid), 0);
        check("t4_req_addr", bus.imem_req_addr, 32'h200);
        wait_acc(base + 4, "t4_wait2");
        check("t4_redir_addr", acc_addr[base + 3], 32'h200);

        // Misaligned target parks in FAULT until an aligned redirect.
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step(1);
        redirect_valid = 1'b0;
        check("t5_fault_set", 32'(misaligned_fault), 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid || bus.instr_valid || !misaligned_fault)
                bad++;
        end
        check("t5_fault_quiet", 32'(bad), 0);
        @(posedge clk);
        #1;
        base = acc_addr.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        check("t5_fault_clr", 32'(misaligned_fault), 0);
        check("t5_req_addr", bus.imem_req_addr, 32'h300);
        wait_acc(base + 1, "t5_wait");
        check("t5_redir_addr", acc_addr[base], 32'h300);

        // Reset while waiting, then a stray response right after release.
        rsp_delay = 4;
        base = acc_addr.size();
        step(2);
        wait_acc(base + 1, "t6_wait");
        rsp_delay = 2;
        do_reset();
        inject_cyc = cyc;
        base = acc_addr.size();
        step(1);
        check("t6_stray_ignored", 32'(bus.instr_valid), 0);
        wait_acc(base + 1, "t6_wait2");
        check("t6_first_addr", acc_addr[base], 32'h0);
        p0 = pops;
        step(3);
        check("t6_pops", 32'(pops - p0), 1);

        step(2);
        check("spurious_pops", 32'(spurious), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
